// File: rtl/mil_tx_queue_pkg.sv
// Shared MIL-STD-1553 word definitions used by the transmit-side queue and transceiver.
package milStd1553;

    typedef enum logic [1:0] {
        WSERV = 2'd0,
        WDATA = 2'd1,
        WERR  = 2'd2,
        WNONE = 2'd3
    } milWordType_t;

    typedef struct packed {
        milWordType_t dataType;
        logic [15:0]  dataWord;
    } MilData;

endpackage

// File: rtl/mil_fifo_ram.sv
// Dual-pointer storage array for queued 1553 words: synchronous write, asynchronous read.
module mil_fifo_ram
    import milStd1553::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wrEn_i,
    input  logic [AW-1:0] wrAddr_i,
    input  MilData        wrData_i,
    input  logic [AW-1:0] rdAddr_i,
    output MilData        rdData_o
);

    MilData mem_q [DEPTH];

    // No reset on the array; the level counter alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (wrEn_i) begin
            mem_q[wrAddr_i] <= wrData_i;
        end
    end

    assign rdData_o = mem_q[rdAddr_i];

endmodule

// File: rtl/mil_tx_queue.sv
// Transmit word queue feeding the transceiver push port, with a programmable inter-word idle gap.
module mil_tx_queue
    import milStd1553::*;
#(
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 0
) (
    input  logic                   clk,
    input  logic                   nRst,
    input  logic                   in_request,
    input  logic [1:0]             in_type,
    input  logic [15:0]            in_word,
    output logic                   in_done,
    output logic                   out_request,
    output logic [1:0]             out_type,
    output logic [15:0]            out_word,
    input  logic                   out_done,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = $clog2(GAP_CYCLES + 1) + 1;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_PRESENT,
        TX_GAP
    } txState_t;

    txState_t        state_q, state_d;
    logic [AW-1:0]   wrPtr_q, wrPtr_d;
    logic [AW-1:0]   rdPtr_q, rdPtr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            overflow_q, overflow_d;
    logic            inDone_q, inDone_d;
    logic [GW-1:0]   gapCnt_q, gapCnt_d;
    logic [1:0]      outType_q, outType_d;
    logic [15:0]     outWord_q, outWord_d;
    logic            wrEn;
    logic            popEn;
    logic            headLatch;
    MilData          wrData;
    MilData          rdData;

    assign wrData = '{dataType: milWordType_t'(in_type), dataWord: in_word};

    mil_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk      (clk),
        .wrEn_i   (wrEn),
        .wrAddr_i (wrPtr_q),
        .wrData_i (wrData),
        .rdAddr_i (rdPtr_q),
        .rdData_o (rdData)
    );

    // Flush wins over everything: it blocks the write, the pop and the head latch alike.
    always_comb begin
        wrEn       = in_request && !full_q && !flush;
        popEn      = (state_q == TX_PRESENT) && out_done && !flush;
        headLatch  = (state_q == TX_IDLE) && !empty_q && !flush;

        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        inDone_d   = wrEn;
        outType_d  = outType_q;
        outWord_d  = outWord_q;

        if (flush) begin
            wrPtr_d    = '0;
            rdPtr_d    = '0;
            level_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (wrEn) begin
                wrPtr_d = wrPtr_q + AW'(1);
            end
            if (popEn) begin
                rdPtr_d = rdPtr_q + AW'(1);
            end
            if (in_request && full_q) begin
                overflow_d = 1'b1;
            end
            level_d = level_q + LW'(wrEn) - LW'(popEn);
        end

        if (headLatch) begin
            outType_d = rdData.dataType;
            outWord_d = rdData.dataWord;
        end

        full_d  = (level_d == LW'(DEPTH));
        empty_d = (level_d == '0);
    end

    // Output handshake FSM; the GAP state is only ever entered when GAP_CYCLES is non-zero.
    always_comb begin
        state_d     = state_q;
        gapCnt_d    = gapCnt_q;
        out_request = 1'b0;

        unique case (state_q)
            TX_IDLE: begin
                if (headLatch) begin
                    state_d = TX_PRESENT;
                end
            end
            TX_PRESENT: begin
                out_request = 1'b1;
                if (popEn) begin
                    gapCnt_d = '0;
                    state_d  = (GAP_CYCLES == 0) ? TX_IDLE : TX_GAP;
                end
            end
            TX_GAP: begin
                if (gapCnt_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = TX_IDLE;
                end else begin
                    gapCnt_d = gapCnt_q + GW'(1);
                end
            end
            default: state_d = TX_IDLE;
        endcase

        if (flush) begin
            state_d  = TX_IDLE;
            gapCnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q    <= TX_IDLE;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            inDone_q   <= 1'b0;
            gapCnt_q   <= '0;
            outType_q  <= '0;
            outWord_q  <= '0;
        end else begin
            state_q    <= state_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            inDone_q   <= inDone_d;
            gapCnt_q   <= gapCnt_d;
            outType_q  <= outType_d;
            outWord_q  <= outWord_d;
        end
    end

    assign in_done  = inDone_q;
    assign out_type = outType_q;
    assign out_word = outWord_q;
    assign level    = level_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_mil_tx_queue.sv
// Directed self-checking bench for mil_tx_queue: one instance without gap, one with GAP_CYCLES=5.
module tb_mil_tx_queue;
    import milStd1553::*;

    logic        clk;
    logic        nRst;

    logic        in_request;
    logic [1:0]  in_type;
    logic [15:0] in_word;
    logic        in_done;
    logic        out_request;
    logic [1:0]  out_type;
    logic [15:0] out_word;
    logic        out_done;
    logic        flush;
    logic [4:0]  level;
    logic        full;
    logic        empty;
    logic        overflow;

    logic        gReq;
    logic [1:0]  gType;
    logic [15:0] gWord;
    logic        gInDone;
    logic        gOutReq;
    logic [1:0]  gOutType;
    logic [15:0] gOutWord;
    logic        gDone;
    logic        gFlush;
    logic [4:0]  gLevel;
    logic        gFull;
    logic        gEmpty;
    logic        gOverflow;

    int checkCount = 0;
    int failCount  = 0;

    mil_tx_queue #(.DEPTH(16), .GAP_CYCLES(0)) dut (
        .clk         (clk),
        .nRst        (nRst),
        .in_request  (in_request),
        .in_type     (in_type),
        .in_word     (in_word),
        .in_done     (in_done),
        .out_request (out_request),
        .out_type    (out_type),
        .out_word    (out_word),
        .out_done    (out_done),
        .flush       (flush),
        .level       (level),
        .full        (full),
        .empty       (empty),
        .overflow    (overflow)
    );

    mil_tx_queue #(.DEPTH(16), .GAP_CYCLES(5)) dutGap (
        .clk         (clk),
        .nRst        (nRst),
        .in_request  (gReq),
        .in_type     (gType),
        .in_word     (gWord),
        .in_done     (gInDone),
        .out_request (gOutReq),
        .out_type    (gOutType),
        .out_word    (gOutWord),
        .out_done    (gDone),
        .flush       (gFlush),
        .level       (gLevel),
        .full        (gFull),
        .empty       (gEmpty),
        .overflow    (gOverflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: every check in the bench is counted and reported here.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives the main instance's inputs for one clock edge and leaves us 1ns after that edge.
    task automatic applyStimulus(input logic req, input logic [1:0] ty, input logic [15:0] w,
                                 input logic done, input logic fl);
        in_request = req;
        in_type    = ty;
        in_word    = w;
        out_done   = done;
        flush      = fl;
        tick();
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 2'd0, 16'h0000, 1'b0, 1'b0);
    endtask

    // Waits (bounded) for a presented word, checks it, then acknowledges it.
    task automatic drainExpect(input string tag, input logic [15:0] expWord);
        int waited = 0;
        while (!out_request && waited < 20) begin
            idleCycle();
            waited++;
        end
        checkOutput({tag, "_word"}, 32'(out_word), 32'(expWord));
        applyStimulus(1'b0, 2'd0, 16'h0000, 1'b1, 1'b0);
    endtask

    initial begin
        int maxLevel;
        int written;
        int popped;
        int cycles;
        int lowCount;

        nRst = 1'b0;
        in_request = 1'b0; in_type = 2'd0; in_word = 16'h0; out_done = 1'b0; flush = 1'b0;
        gReq = 1'b0; gType = 2'd0; gWord = 16'h0; gDone = 1'b0; gFlush = 1'b0;

        tick();
        checkOutput("rst_in_done",  32'(in_done), 32'd0);
        checkOutput("rst_out_req",  32'(out_request), 32'd0);
        checkOutput("rst_out_type", 32'(out_type), 32'd0);
        checkOutput("rst_out_word", 32'(out_word), 32'd0);
        checkOutput("rst_level",    32'(level), 32'd0);
        checkOutput("rst_full",     32'(full), 32'd0);
        checkOutput("rst_empty",    32'(empty), 32'd1);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_gap_empty", 32'(gEmpty), 32'd1);
        nRst = 1'b1;
        tick();

        $display("[TB] two-word write and replay");
        applyStimulus(1'b1, WSERV, 16'h1111, 1'b0, 1'b0);
        checkOutput("w1_in_done", 32'(in_done), 32'd1);
        checkOutput("w1_level",   32'(level), 32'd1);
        checkOutput("w1_out_req", 32'(out_request), 32'd0);
        applyStimulus(1'b1, WDATA, 16'h2222, 1'b0, 1'b0);
        checkOutput("w2_in_done", 32'(in_done), 32'd1);
        checkOutput("w2_level",   32'(level), 32'd2);
        checkOutput("w2_out_req", 32'(out_request), 32'd1);
        checkOutput("w2_out_word", 32'(out_word), 32'h1111);
        checkOutput("w2_out_type", 32'(out_type), 32'(WSERV));
        idleCycle();
        checkOutput("hold_in_done", 32'(in_done), 32'd0);
        checkOutput("hold_out_word", 32'(out_word), 32'h1111);
        applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 1'b0);
        checkOutput("pop1_level",   32'(level), 32'd1);
        checkOutput("pop1_out_req", 32'(out_request), 32'd0);
        applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 1'b0);
        checkOutput("idle_done_level", 32'(level), 32'd1);
        checkOutput("p2_out_req",  32'(out_request), 32'd1);
        checkOutput("p2_out_word", 32'(out_word), 32'h2222);
        checkOutput("p2_out_type", 32'(out_type), 32'(WDATA));
        applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 1'b0);
        checkOutput("pop2_empty", 32'(empty), 32'd1);
        idleCycle();

        $display("[TB] fill to full, overflow, drain");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, WDATA, 16'(i), 1'b0, 1'b0);
        end
        checkOutput("fill_level", 32'(level), 32'd16);
        checkOutput("fill_full",  32'(full), 32'd1);
        applyStimulus(1'b1, WDATA, 16'hDEAD, 1'b0, 1'b0);
        checkOutput("ovf_in_done",  32'(in_done), 32'd0);
        checkOutput("ovf_overflow", 32'(overflow), 32'd1);
        checkOutput("ovf_level",    32'(level), 32'd16);
        for (int i = 0; i < 16; i++) begin
            drainExpect($sformatf("drain%0d", i), 16'(i));
        end
        checkOutput("drain_empty", 32'(empty), 32'd1);
        checkOutput("drain_overflow_sticky", 32'(overflow), 32'd1);
        applyStimulus(1'b0, 2'd0, 16'h0, 1'b0, 1'b1);
        checkOutput("flush_clr_overflow", 32'(overflow), 32'd0);
        idleCycle();

        $display("[TB] continuous write and drain with pointer wrap");
        maxLevel = 0; written = 0; popped = 0; cycles = 0;
        while (popped < 40 && cycles < 400) begin
            logic doWrite;
            logic doPop;
            doWrite = (written < 40) && (cycles % 2 == 0);
            doPop   = out_request;
            if (doPop) begin
                checkOutput($sformatf("wrap_word%0d", popped), 32'(out_word), 32'(16'h1000 + 16'(popped)));
                popped++;
            end
            applyStimulus(doWrite, WDATA, 16'h1000 + 16'(written), doPop, 1'b0);
            if (doWrite) written++;
            if (int'(level) > maxLevel) maxLevel = int'(level);
            cycles++;
        end
        checkOutput("wrap_popped", 32'(popped), 32'd40);
        checkOutput("wrap_level_bound", 32'(maxLevel <= 16), 32'd1);
        idleCycle();
        idleCycle();

        $display("[TB] flush while presenting");
        applyStimulus(1'b1, WDATA, 16'hA001, 1'b0, 1'b0);
        applyStimulus(1'b1, WDATA, 16'hA002, 1'b0, 1'b0);
        applyStimulus(1'b1, WDATA, 16'hA003, 1'b0, 1'b0);
        checkOutput("pre_flush_level", 32'(level), 32'd3);
        checkOutput("pre_flush_req",   32'(out_request), 32'd1);
        applyStimulus(1'b1, WDATA, 16'hBEEF, 1'b1, 1'b1);
        checkOutput("flush_level",    32'(level), 32'd0);
        checkOutput("flush_empty",    32'(empty), 32'd1);
        checkOutput("flush_overflow", 32'(overflow), 32'd0);
        checkOutput("flush_out_req",  32'(out_request), 32'd0);
        checkOutput("flush_in_done",  32'(in_done), 32'd0);
        idleCycle();
        checkOutput("post_flush_req", 32'(out_request), 32'd0);

        $display("[TB] async reset mid-present");
        applyStimulus(1'b1, WSERV, 16'hCCCC, 1'b0, 1'b0);
        idleCycle();
        checkOutput("pre_rst_req", 32'(out_request), 32'd1);
        #2 nRst = 1'b0;
        #1;
        checkOutput("arst_out_req",  32'(out_request), 32'd0);
        checkOutput("arst_out_word", 32'(out_word), 32'd0);
        checkOutput("arst_level",    32'(level), 32'd0);
        checkOutput("arst_empty",    32'(empty), 32'd1);
        #2 nRst = 1'b1;
        tick();
        applyStimulus(1'b1, WDATA, 16'hBBBB, 1'b0, 1'b0);
        checkOutput("rearm_level", 32'(level), 32'd1);
        idleCycle();
        checkOutput("rearm_type", 32'(out_type), 32'(WDATA));
        drainExpect("rearm", 16'hBBBB);
        checkOutput("rearm_empty", 32'(empty), 32'd1);

        $display("[TB] inter-word gap of 5 cycles");
        gReq = 1'b1; gType = WDATA; gWord = 16'h5001; tick();
        gWord = 16'h5002; tick();
        gReq = 1'b0;
        cycles = 0;
        while (!gOutReq && cycles < 20) begin tick(); cycles++; end
        checkOutput("gap_first_word", 32'(gOutWord), 32'h5001);
        gDone = 1'b1; tick(); gDone = 1'b0;
        lowCount = 0;
        while (!gOutReq && lowCount < 30) begin lowCount++; tick(); end
        checkOutput("gap_low_cycles", 32'(lowCount), 32'd6);
        checkOutput("gap_second_word", 32'(gOutWord), 32'h5002);
        gDone = 1'b1; tick(); gDone = 1'b0;
        checkOutput("gap_empty", 32'(gEmpty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
